hdmi_cfg_sequencer: RTL and testbench
=====================================

// Module: hdmi_cfg_sequencer
// PURPOSE
//  Sequences the HDMI transmitter's register configuration over I2C. After reset and a power-up
//  settle delay, walks a register table held in an external sync ROM. Each {reg,data} entry becomes
//  one write request to the I2C byte-write master. Failed writes are retried. The whole table is
//  re-run when the transmitter raises its interrupt (hot-plug). Sits between the 50 MHz clock
//  domain and the I2C master, replacing free-running config logic.
// PARAMETERS
//  NUM_REGS        31        table entries, ROM addresses 0..NUM_REGS-1 (NUM_REGS >= 1)
//  ADDR_W          5         ROM address width, 2**ADDR_W >= NUM_REGS
//  DEV_ADDR        8'h72     I2C device write address driven on oI2C_DEV
//  STARTUP_CYCLES  10000000  settle delay before first write (0 = none)
//  MAX_RETRY       3         retries per entry after a NACK before error
//  RETRY_GAP       50000     idle cycles between NACK and retry (>= 1)
// PORTS
//  iCLK        in   1       system clock (50 MHz)
//  iRST        in   1       asynchronous reset, active-high
//  iTX_INT     in   1       transmitter interrupt, active-low, asynchronous; 2-FF synchronised
//  oROM_ADDR   out  ADDR_W  table index; ROM returns data one cycle later
//  iROM_DATA   in   16      {reg[15:8], data[7:0]} for the previous cycle's oROM_ADDR
//  oI2C_REQ    out  1       write request, held until iI2C_DONE
//  oI2C_DEV    out  8       device address (constant DEV_ADDR)
//  oI2C_REG    out  8       register address
//  oI2C_DATA   out  8       register data
//  iI2C_DONE   in   1       1-cycle pulse: transfer finished
//  iI2C_NACK   in   1       qualifies iI2C_DONE: 1 = slave NACKed
//  oCFG_DONE   out  1       table fully written, 1 in DONE state
//  oCFG_ERR    out  1       entry exhausted retries, 1 in ERROR state
//  oBUSY       out  1       1 in any state other than DONE/ERROR
// BEHAVIOUR
//  Reset values: state=SETTLE, oROM_ADDR=0, oI2C_REQ=0, oI2C_REG/DATA=0, oCFG_DONE=0, oCFG_ERR=0,
//   oBUSY=1, all counters 0, synchroniser flops=1 (interrupt inactive).
//  SETTLE: count to STARTUP_CYCLES-1, then FETCH. If STARTUP_CYCLES=0, go to FETCH on the first cycle.
//  FETCH: oROM_ADDR=idx; next cycle -> LATCH (ROM latency).
//  LATCH: capture iROM_DATA into oI2C_REG/DATA, assert oI2C_REQ, -> WRITE.
//  WRITE: REQ and REG/DATA/DEV held stable. iI2C_DONE=1 in WRITE -> REQ=0 the next cycle.
//   NACK=0: retry cnt cleared. idx==NUM_REGS-1 -> DONE, else idx+1 -> FETCH.
//   NACK=1: retry cnt < MAX_RETRY -> cnt+1, -> GAP. Otherwise -> ERROR.
//  GAP: wait RETRY_GAP cycles, then LATCH path re-asserts REQ with the same entry (no re-fetch).
//  DONE / ERROR: outputs held, REQ=0. A synchronised iTX_INT falling edge (1->0) -> idx=0, cnt=0,
//   flags cleared, -> FETCH (no settle delay).
//  iTX_INT edges while busy: ignored; not queued.
//  iI2C_DONE outside WRITE: ignored. iI2C_NACK is only meaningful with DONE.
//  Latency: first REQ rises STARTUP_CYCLES+2 cycles after reset release. Between entries, REQ is
//   low for exactly 2 cycles (FETCH, LATCH).
//  Reset mid-transfer: REQ drops asynchronously; sequence restarts from SETTLE. The I2C master is
//   reset by the same iRST.
//  Widths: idx=ADDR_W, retry cnt=$clog2(MAX_RETRY+1), counter=$clog2(max(STARTUP_CYCLES,RETRY_GAP)+1).
//   No wrap: idx never exceeds NUM_REGS-1.
// TESTING
//  1 STARTUP_CYCLES=20, NUM_REGS=3, ROM={1234,5678,9ABC}, ACK every write -> first REQ at cycle 22;
//    writes (12,34),(56,78),(9A,BC) in order; oCFG_DONE=1, oBUSY=0 after third DONE.
//  2 NACK on entry 1 twice, then ACK, MAX_RETRY=3 -> entry 1 issued 3 times, each retry
//    RETRY_GAP cycles after NACK; completes with oCFG_ERR=0.
//  3 NACK entry 0 on every attempt -> 4 attempts (1+MAX_RETRY), then oCFG_ERR=1, oBUSY=0, REQ stays 0.
//  4 In DONE, pulse iTX_INT low for 3 cycles -> table rerun from idx 0 without settle delay;
//    a second pulse during the rerun is ignored.
//  5 Assert iRST while REQ=1 mid-entry 2 -> REQ=0 immediately; after release, SETTLE and restart
//    at entry 0.
//  6 Stall iI2C_DONE 1000 cycles -> REQ, REG and DATA stable throughout; a spurious DONE in SETTLE
//    has no effect.

Source files
------------

// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter configuration sequencer: walks a {reg,data} ROM table and issues I2C byte
// writes with NACK retry, and re-runs the table on a transmitter interrupt (hot-plug).
`timescale 1ns/1ps

module hdmi_cfg_sequencer #(
   parameter int         NUM_REGS       = 31,
   parameter int         ADDR_W         = 5,
   parameter logic [7:0] DEV_ADDR       = 8'h72,
   parameter int         STARTUP_CYCLES = 10000000,
   parameter int         MAX_RETRY      = 3,
   parameter int         RETRY_GAP      = 50000
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iTX_INT,
   output logic [ADDR_W-1:0] oROM_ADDR,
   input  logic [15:0]       iROM_DATA,
   output logic              oI2C_REQ,
   output logic [7:0]        oI2C_DEV,
   output logic [7:0]        oI2C_REG,
   output logic [7:0]        oI2C_DATA,
   input  logic              iI2C_DONE,
   input  logic              iI2C_NACK,
   output logic              oCFG_DONE,
   output logic              oCFG_ERR,
   output logic              oBUSY
);

   localparam int CNT_MAX = (STARTUP_CYCLES > RETRY_GAP) ? STARTUP_CYCLES : RETRY_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(RETRY_GAP - 1);
   localparam logic [RTY_W-1:0]  RTY_LIMIT   = RTY_W'(MAX_RETRY);
   localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);

   localparam logic [2:0] ST_SETTLE = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_LATCH  = 3'd2;
   localparam logic [2:0] ST_WRITE  = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERROR  = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [RTY_W-1:0]  rty_q, rty_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [7:0]        reg_q, reg_d;
   logic [7:0]        data_q, data_d;
   logic              int_meta_q, int_sync_q, int_prev_q;
   logic              int_fall;

   // Interrupt is active-low; a synchronised 1->0 transition requests a table re-run.
   assign int_fall = int_prev_q & ~int_sync_q;

   always_comb begin
      // NOTE: every _d gets a default here so no path through the case infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      rty_d   = rty_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      reg_d   = reg_q;
      data_d  = data_q;
      case (state_q)
         ST_SETTLE: begin
            if (STARTUP_CYCLES == 0 || cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FETCH: state_d = ST_LATCH;
         ST_LATCH: begin
            reg_d   = iROM_DATA[15:8];
            data_d  = iROM_DATA[7:0];
            req_d   = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (iI2C_DONE) begin
               req_d = 1'b0;
               if (!iI2C_NACK) begin
                  rty_d = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = ST_FETCH;
                  end
               end else if (rty_q < RTY_LIMIT) begin
                  rty_d   = rty_q + 1'b1;
                  cnt_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_GAP: begin
            // Retry re-uses the captured entry, so the ROM is not re-read.
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               req_d   = 1'b1;
               state_d = ST_WRITE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (int_fall) begin
               idx_d   = '0;
               rty_d   = '0;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q    <= ST_SETTLE;
         idx_q      <= '0;
         rty_q      <= '0;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         reg_q      <= '0;
         data_q     <= '0;
         int_meta_q <= 1'b1;
         int_sync_q <= 1'b1;
         int_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q    <= state_d;
         idx_q      <= idx_d;
         rty_q      <= rty_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         reg_q      <= reg_d;
         data_q     <= data_d;
         int_meta_q <= iTX_INT;
         int_sync_q <= int_meta_q;
         int_prev_q <= int_sync_q;
      end
   end

   assign oROM_ADDR = idx_q;
   assign oI2C_REQ  = req_q;
   assign oI2C_DEV  = DEV_ADDR;
   assign oI2C_REG  = reg_q;
   assign oI2C_DATA = data_q;
   assign oCFG_DONE = (state_q == ST_DONE);
   assign oCFG_ERR  = (state_q == ST_ERROR);
   assign oBUSY     = (state_q != ST_DONE) && (state_q != ST_ERROR);

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Scoreboard bench for hdmi_cfg_sequencer: a table-level model predicts every write attempt,
// a responder plays the I2C master, and a monitor compares each request and its timing.
`timescale 1ns/1ps

module tb_hdmi_cfg_sequencer;

   localparam int         NUM_REGS  = 3;
   localparam int         ADDR_W    = 5;
   localparam int         STARTUP   = 20;
   localparam int         MAX_RETRY = 3;
   localparam int         RETRY_GAP = 8;
   localparam logic [7:0] DEV       = 8'h72;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tx_int = 1'b1;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic              req;
   logic [7:0]        dev, reg_o, data_o;
   logic              i2c_done = 1'b0;
   logic              i2c_nack = 1'b0;
   logic              cfg_done, cfg_err, busy;

   hdmi_cfg_sequencer #(
      .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DEV_ADDR(DEV),
      .STARTUP_CYCLES(STARTUP), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
   ) dut (
      .iCLK(clk), .iRST(rst), .iTX_INT(tx_int),
      .oROM_ADDR(rom_addr), .iROM_DATA(rom_data),
      .oI2C_REQ(req), .oI2C_DEV(dev), .oI2C_REG(reg_o), .oI2C_DATA(data_o),
      .iI2C_DONE(i2c_done), .iI2C_NACK(i2c_nack),
      .oCFG_DONE(cfg_done), .oCFG_ERR(cfg_err), .oBUSY(busy)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous ROM: data for the address presented on the previous edge.
   logic [15:0] rom [0:31];
   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct {
      logic [7:0] r;
      logic [7:0] d;
      bit         nack;
   } wr_t;

   wr_t exp_q[$];
   bit  nack_q[$];
   int  nack_plan[NUM_REGS];
   bit  exp_err;
   int  rel_cyc = 0;
   bit  stall_next = 0;
   bit  spurious_req = 0;
   int  checks = 0;
   int  failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Table-level model: entry i is attempted once plus once per NACK, up to 1+MAX_RETRY times;
   // more NACKs than MAX_RETRY ends the run in error at that entry.
   task automatic plan_run();
      int k;
      int att;
      wr_t w;
      exp_err = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         k   = nack_plan[i];
         att = (k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1;
         for (int a = 0; a < att; a++) begin
            w.r    = rom[i][15:8];
            w.d    = rom[i][7:0];
            w.nack = (a < k);
            exp_q.push_back(w);
            nack_q.push_back(a < k);
         end
         if (k > MAX_RETRY) begin
            exp_err = 1;
            break;
         end
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < NUM_REGS; i++) nack_plan[i] = 0;
   endtask

   task automatic random_rom();
      for (int i = 0; i < NUM_REGS; i++) rom[i] = 16'($urandom);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hot_plug();
      @(negedge clk);
      tx_int = 1'b0;
      cycles(3);
      tx_int = 1'b1;
   endtask

   task automatic wait_run(input string name, input int budget);
      int n;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_finished"}, 32'(busy), 32'(0));
      check({name, "_cfg_done"}, 32'(cfg_done), 32'(!exp_err));
      check({name, "_cfg_err"}, 32'(cfg_err), 32'(exp_err));
      check({name, "_req_idle"}, 32'(req), 32'(0));
      check({name, "_queue_drained"}, 32'(exp_q.size()), 32'(0));
   endtask

   // Responder: plays the I2C byte-write master, answering each request after a latency.
   initial begin
      int lat;
      lat = -1;
      forever begin
         @(negedge clk);
         i2c_done = 1'b0;
         i2c_nack = 1'b0;
         if (rst) begin
            lat = -1;
         end else if (req) begin
            if (lat < 0) begin
               lat = stall_next ? 1000 : int'($urandom_range(0, 4));
               stall_next = 0;
            end
            if (lat == 0) begin
               i2c_done = 1'b1;
               i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
               lat = -1;
            end else begin
               lat--;
            end
         end else begin
            lat = -1;
            if (spurious_req) begin
               i2c_done = 1'b1;
               i2c_nack = 1'($urandom_range(0, 1));
               spurious_req = 0;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every request, checks hold stability and spacing.
   initial begin
      logic       req_prev;
      logic [7:0] rise_r, rise_d;
      bit         stable_ok, cur_nack, last_nack, after_reset;
      int         last_done_cyc;
      wr_t        w;
      req_prev = 1'b0; after_reset = 1; last_done_cyc = -1;
      stable_ok = 1; cur_nack = 0; last_nack = 0; rise_r = '0; rise_d = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            req_prev = 1'b0;
            last_done_cyc = -1;
            after_reset = 1;
         end else begin
            if (req && !req_prev) begin
               check("req_expected", 32'(exp_q.size() != 0), 32'(1));
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  check("req_reg", 32'(reg_o), 32'(w.r));
                  check("req_data", 32'(data_o), 32'(w.d));
                  check("req_dev", 32'(dev), 32'(DEV));
                  cur_nack = w.nack;
               end
               if (after_reset)
                  check("first_req_latency", 32'(cyc - rel_cyc), 32'(STARTUP + 2));
               else if (last_done_cyc >= 0)
                  check("req_gap", 32'(cyc - last_done_cyc), 32'(last_nack ? RETRY_GAP : 2));
               after_reset = 0;
               rise_r = reg_o;
               rise_d = data_o;
               stable_ok = 1;
            end else if (req && req_prev) begin
               if (reg_o !== rise_r || data_o !== rise_d || dev !== DEV) stable_ok = 0;
            end else if (!req && req_prev) begin
               check("hold_stable", 32'(stable_ok), 32'(1));
               last_done_cyc = cyc;
               last_nack = cur_nack;
            end
            if (cfg_done || cfg_err) last_done_cyc = -1;
            req_prev = req;
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish within 60000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
      rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'h9ABC;

      // Reset values, then the basic table walk with a spurious DONE during settle.
      cycles(3);
      check("rst_req", 32'(req), 32'(0));
      check("rst_rom_addr", 32'(rom_addr), 32'(0));
      check("rst_reg", 32'(reg_o), 32'(0));
      check("rst_data", 32'(data_o), 32'(0));
      check("rst_cfg_done", 32'(cfg_done), 32'(0));
      check("rst_cfg_err", 32'(cfg_err), 32'(0));
      check("rst_busy", 32'(busy), 32'(1));
      clear_plan();
      plan_run();
      spurious_req = 1;
      rst = 1'b0;
      rel_cyc = cyc;
      wait_run("basic", 500);

      // Entry 1 NACKed twice, then ACKed.
      random_rom();
      clear_plan();
      nack_plan[1] = 2;
      plan_run();
      hot_plug();
      wait_run("retry", 1000);

      // Hot-plug rerun; a second interrupt pulse during the rerun must be ignored.
      random_rom();
      clear_plan();
      plan_run();
      hot_plug();
      n = 0;
      while (!req && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("rerun_started", 32'(req), 32'(1));
      hot_plug();
      wait_run("rerun", 1000);
      cycles(20);
      check("no_second_rerun", 32'(busy), 32'(0));

      // Entry 0 NACKed on every attempt -> error, REQ stays low afterwards.
      random_rom();
      clear_plan();
      nack_plan[0] = MAX_RETRY + 1;
      plan_run();
      hot_plug();
      wait_run("error", 1000);
      cycles(20);
      check("error_req_low", 32'(req), 32'(0));
      check("error_held", 32'(cfg_err), 32'(1));

      // Randomized reruns, including recovery from the error state.
      for (int it = 0; it < 6; it++) begin
         random_rom();
         for (int i = 0; i < NUM_REGS; i++)
            nack_plan[i] = ($urandom_range(0, 4) == 0) ? MAX_RETRY + 1 : int'($urandom_range(0, 2));
         plan_run();
         hot_plug();
         wait_run("random", 2000);
      end

      // DONE withheld for 1000 cycles on the first entry.
      random_rom();
      clear_plan();
      plan_run();
      stall_next = 1;
      hot_plug();
      wait_run("stall", 3000);

      // Reset while entry 2 is being written.
      random_rom();
      clear_plan();
      plan_run();
      hot_plug();
      n = 0;
      while (!(req && rom_addr == 2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_entry2", 32'(req && rom_addr == 2), 32'(1));
      #3 rst = 1'b1;
      #1 check("rst_req_async", 32'(req), 32'(0));
      check("rst_busy_again", 32'(busy), 32'(1));
      cycles(3);
      exp_q.delete();
      nack_q.delete();
      check("rst_rom_addr_again", 32'(rom_addr), 32'(0));
      random_rom();
      clear_plan();
      plan_run();
      rst = 1'b0;
      rel_cyc = cyc;
      wait_run("post_reset", 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
